// File: rtl/dac_pkg.sv
// Shared DAC code type and constants for the R-2R DAC scheduler.
package dac_pkg;

    localparam int unsigned DAC_W = 10;

    typedef logic [DAC_W-1:0] dac_code_t;

    localparam dac_code_t DAC_MIDSCALE = 10'd512;
    localparam dac_code_t DAC_MAX      = 10'd1023;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit scanning upward from last+1 mod N.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    input  logic                 en,
    output logic [N-1:0]         gnt_next,
    output logic [$clog2(N)-1:0] sel
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        idx      = 0;
        gnt_next = '0;
        sel      = '0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
        if (en && found) begin
            gnt_next[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/dac_scheduler.sv
// Time-multiplexes the 10-bit R-2R DAC (dac_code[0..9] -> D0..D9) between NUM_SRC sources.
// Optional idle midscale return is enabled by defining DAC_IDLE_MIDSCALE_EN.
module dac_scheduler
    import dac_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned PRESCALE   = 10,
    parameter int unsigned IDLE_TICKS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC*DAC_W-1:0]   src_code,
    output logic [NUM_SRC-1:0]         grant,
    output dac_code_t                  dac_code,
    output logic                       dac_update,
    output logic [$clog2(NUM_SRC)-1:0] active_src
);

    localparam int unsigned IW = $clog2(NUM_SRC);
    localparam int unsigned PW = $clog2(PRESCALE);

    if (NUM_SRC < 2 || NUM_SRC > 8 || PRESCALE < 2 || IDLE_TICKS < 1) begin : g_bad_param
        $error("dac_scheduler: parameter out of range");
    end

    logic [PW-1:0]      pcnt;
    logic               tick;
    logic [IW-1:0]      last;
    logic [NUM_SRC-1:0] gnt_next;
    logic [IW-1:0]      sel;
    logic               any_req;
    dac_code_t          sel_code;

    assign tick     = (pcnt == PW'(PRESCALE - 1));
    assign any_req  = |req;
    assign sel_code = src_code[32'(sel)*DAC_W +: DAC_W];

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_arb (
        .req      (req),
        .last     (last),
        .en       (tick),
        .gnt_next (gnt_next),
        .sel      (sel)
    );

`ifdef DAC_IDLE_MIDSCALE_EN
    localparam int unsigned CW = $clog2(IDLE_TICKS + 1);

    logic [CW-1:0] idle_cnt;
    logic          idle_fire;

    // Fires only on the tick that takes the counter to IDLE_TICKS; saturation blocks repeats.
    assign idle_fire = tick && !any_req && (idle_cnt == CW'(IDLE_TICKS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (tick) begin
            if (any_req) begin
                idle_cnt <= '0;
            end else if (idle_cnt != CW'(IDLE_TICKS)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt       <= '0;
            dac_code   <= '0;
            grant      <= '0;
            dac_update <= 1'b0;
            active_src <= '0;
            last       <= IW'(NUM_SRC - 1);
        end else begin
            pcnt       <= tick ? '0 : pcnt + 1'b1;
            grant      <= '0;
            dac_update <= 1'b0;
            if (tick && any_req) begin
                grant      <= gnt_next;
                dac_update <= 1'b1;
                dac_code   <= sel_code;
                active_src <= sel;
                last       <= sel;
            end
`ifdef DAC_IDLE_MIDSCALE_EN
            else if (idle_fire) begin
                dac_code   <= DAC_MIDSCALE;
                dac_update <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/dac_scheduler.md
# dac_scheduler

Time-multiplexes the board's 10-bit parallel R-2R DAC output (pins D0–D9) between up to `NUM_SRC` waveform sources such as sawtooth, triangle and square generators. A prescaler produces a sample tick. On each tick, a round-robin arbiter picks one requesting source and latches its code into the DAC output register. The top level maps `dac_code` bit 0..9 onto D0..D9.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesting sources, 2..8.
- `PRESCALE`, 10: clock cycles per sample tick, minimum 2.
- `IDLE_TICKS`, 16: consecutive request-free ticks before the idle action (only with `DAC_IDLE_MIDSCALE_EN`).

Ports:
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req`, in, `NUM_SRC`: per-source sample request; level, held until granted.
- `src_code`, in, `NUM_SRC*10`: source i's code in bits [10i+9:10i]; must be stable while `req[i]` is high.
- `grant`, out, `NUM_SRC`: one-hot, one-cycle pulse; source accepted.
- `dac_code`, out, 10: registered DAC code.
- `dac_update`, out, 1: one-cycle pulse; `dac_code` changed source/value this cycle.
- `active_src`, out, `$clog2(NUM_SRC)`: index of the last granted source.

## Operation
- Prescaler `pcnt` counts 0..`PRESCALE-1` and wraps. `tick` is the internal combinational signal `pcnt == PRESCALE-1`.
- On a tick cycle with `req != 0`:
  - Arbiter picks the first set `req` bit, scanning upward from `last+1` mod `NUM_SRC`.
  - At the closing edge, `dac_code <= src_code[sel]`, `active_src <= sel`, `last <= sel`.
  - `grant[sel]` and `dac_update` are registered to 1 for exactly the following cycle.
- Tick cycle with `req == 0`: `dac_code` holds; no grant; no update.
- Non-tick cycles:
  - Requests are ignored and `dac_code` holds.
  - `grant` and `dac_update` are 0, except the registered pulse from the preceding tick.
- Round-robin fairness: with every `req` bit held high, the grant sequence is 0,1,…,NUM_SRC-1,0,…, one grant per tick. A source waits at most `NUM_SRC` ticks.
- Requester contract:
  - On seeing `grant[i]`, the source either drops `req[i]` or presents its next code in the same cycle.
  - Because `PRESCALE >= 2`, the next tick is never the grant cycle.
- No arithmetic is performed on codes. They pass through unmodified, full 10-bit range 0..1023.

## Timing
- Reset values while `rst_n` is low at an edge:
  - `pcnt = 0`, `dac_code = 0`, `grant = 0`, `dac_update = 0`, `active_src = 0`.
  - `last = NUM_SRC-1`, so the first grant scan starts at source 0.
  - Idle counter = 0.
- First tick after reset release: cycle `PRESCALE-1`, counting the release cycle as cycle 0.
- Latency:
  - Request present in a tick cycle → `dac_code` valid and `grant` high one cycle later.
  - Worst case from assertion to grant: `NUM_SRC*PRESCALE` cycles.
- Reset asserted mid-operation:
  - Pending grant/update pulses are cancelled.
  - `dac_code` returns to 0 on that edge and the prescaler restarts.
- A source that drops `req` before its tick is not granted. There is no memory of past requests.

## Configuration
- `DAC_IDLE_MIDSCALE_EN` defined:
  - An idle counter increments on each tick with `req == 0` and clears on any tick with `req != 0`.
  - When it reaches `IDLE_TICKS`, `dac_code <= 512` (midscale) at that tick's edge, with `dac_update` pulsed once and no grant.
  - The counter then saturates, so there are no further updates until a request is served.
- `DAC_IDLE_MIDSCALE_EN` undefined: no idle counter; `dac_code` holds its last value indefinitely.

## Structure
- Package `dac_pkg`:
  - `DAC_W = 10`
  - `typedef logic [DAC_W-1:0] dac_code_t`
  - `DAC_MIDSCALE = 10'd512`
  - `DAC_MAX = 10'd1023`
- Sub-module `rr_arbiter`, parameterised by N:
  - Inputs: `req`, `last`, `en`.
  - Outputs: one-hot `gnt_next` and `sel` index, purely combinational.
  - `dac_scheduler` owns the prescaler, all registers and the idle logic.

## Test plan
- Reset/first tick: `NUM_SRC=4`, `PRESCALE=10`, `req=4'b0001`, `src_code[0]=300`, release `rst_n` at cycle 0 → `grant=4'b0001`, `dac_update=1`, `dac_code=300` at cycle 10; outputs 0 before that.
- Round robin: all `req` held high, codes 100/200/300/400 → grants 0,1,2,3,0 on consecutive ticks spaced 10 cycles; `dac_code` 100,200,300,400,100.
- Skip idle sources: `req=4'b1010` with `last=1` → next grant is source 3, then source 1.
- Hold/no-request: `dac_code=700`, then `req=0` for 5 ticks → `dac_code` stays 700 and `dac_update` stays 0 (macro undefined).
- Idle midscale (`DAC_IDLE_MIDSCALE_EN`, `IDLE_TICKS=16`): `req=0` after a grant → `dac_code=512` with a single `dac_update` at the 16th idle tick; a new request then restores normal grants.
- Mid-run reset: `rst_n` low for 1 cycle while `dac_code=1023` and a grant pulse is pending → next cycle `dac_code=0`, `grant=0`, first new tick 10 cycles after release.
